instr_sequencer: RTL and testbench
==================================

// Module: instr_sequencer
// PURPOSE
// Multicycle control unit that reads the instruction register. Sequences fetch, decode and execute for one
// instruction per Run request.
// Drives IR load enable, register-file in/out selects, accumulator/G enables, bus source select and ALU op.
// Sits between the instruction register and the datapath; its IR_E output is the instruction register's E input.
// PARAMETERS
// N     10  instruction width; fields use IR[9:0], bits above 9 ignored; N < 10 illegal
// NREG  8   general registers R0..R7; fixed by 3-bit fields, other values illegal
// PORTS
// CLKb    in   1     system clock; state register updates on rising edge
// Reset   in   1     asynchronous, active-high; forces IDLE
// Run     in   1     start request; sampled only in IDLE
// IR      in   N     instruction register Q; valid from T1 onward
// IR_E    out  1     instruction register load enable
// DINout  out  1     drive external DIN onto bus
// Rin     out  NREG  one-hot register write enables
// Rout    out  NREG  one-hot register bus drivers
// Ain     out  1     load accumulator A from bus
// Gin     out  1     load G from ALU
// Gout    out  1     drive G onto bus
// ALUop   out  2     00 add, 01 sub, 10 and, 11 or
// Done    out  1     one-cycle pulse in last cycle of instruction
// BEHAVIOUR
// Fields: op=IR[9:6], Rx=IR[5:3], Ry=IR[2:0]; op 0000 mv, 0001 mvi, 0010 add, 0011 sub, 0100 and, 0101 or.
// Ops 0110..1111 are NOP.
// States IDLE, T0, T1, T2, T3. Moore on state plus IR fields, decoded from registered state, no input-to-output path.
// Exception: none; Run affects only next state.
// Reset (async, any state): state=IDLE immediately; all outputs 0 while Reset high and in IDLE.
// IDLE: all outputs 0; Run=1 at rising edge -> T0, else stay.
// T0 (fetch): IR_E=1, DINout=1; IR captures on falling edge mid-T0 -> T1.
// T1 (decode):
//  - mv: Rout[Ry]=1, Rin[Rx]=1, Done=1 -> IDLE.
//  - mvi: DINout=1, Rin[Rx]=1, Done=1 -> IDLE; immediate word must be on DIN during T1.
//  - add/sub/and/or: Rout[Rx]=1, Ain=1 -> T2.
//  - NOP: Done=1 -> IDLE.
// T2: Rout[Ry]=1, Gin=1, ALUop=op[1:0] (add 00, sub 01, and 10, or 11) -> T3.
// T3: Gout=1, Rin[Rx]=1, Done=1 -> IDLE.
// ALUop=00 in every state other than T2.
// Latency after Run sampled at edge k: mv/mvi/NOP Done in cycle k+2; ALU ops Done in cycle k+4.
// Return to IDLE after Done costs one cycle.
// Run held high: re-fetches every instruction, one IDLE cycle between instructions.
// Run changes outside IDLE: ignored.
// Rx==Ry allowed: mv R3,R3 asserts Rout[3] and Rin[3] together; add R2,R2 doubles R2.
// Rin and Rout are each one-hot or zero.
// Never assert two bus drivers (DINout, Gout, any Rout) in the same cycle.
// Reset mid-instruction: abandon immediately; no Done; the next instruction starts from T0.
// IR X/changing outside T1..T3 must not affect outputs.
// TESTING
// Reset high in T2 of add -> state IDLE asynchronously; all outputs 0; no Done; Run then restarts at T0.
// mv R1,R5 (IR=0000_001_101), Run 1 cycle -> T0 IR_E=DINout=1; T1 Rout=8'h20, Rin=8'h02, Done=1; then IDLE.
// mvi R7 (IR=0001_111_000), DIN=0x155 in T1 -> T1 DINout=1, Rin=8'h80, Done=1.
// sub R2,R4 (IR=0011_010_100):
//  -> T1 Rout=8'h04 Ain=1; T2 Rout=8'h10 Gin=1 ALUop=01; T3 Gout=1 Rin=8'h04 Done=1.
// op 1010 with Run held high -> Done in T1; back-to-back: IDLE, T0, T1 repeated.
// Check: no bus contention ever.
// Run pulsed during T2 of and -> ignored; instruction completes normally, returns to IDLE, no extra fetch.

Source files
------------

// File: rtl/instr_sequencer.sv
// Multicycle fetch/decode/execute sequencer for a simple bus-based processor.
// One instruction is sequenced per Run request. Control outputs are registered.
// Each output register is loaded from the next state and the instruction fields,
// so no input reaches an output through combinational logic alone.
module instr_sequencer #(
  parameter int unsigned N    = 10,
  parameter int unsigned NREG = 8
) (
  input  logic            CLKb,
  input  logic            Reset,
  input  logic            Run,
  input  logic [N-1:0]    IR,
  output logic            IR_E,
  output logic            DINout,
  output logic [NREG-1:0] Rin,
  output logic [NREG-1:0] Rout,
  output logic            Ain,
  output logic            Gin,
  output logic            Gout,
  output logic [1:0]      ALUop,
  output logic            Done
);

  localparam int unsigned OP_W  = 4;
  localparam int unsigned REG_W = 3;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T0   = 3'd1,
    S_T1   = 3'd2,
    S_T2   = 3'd3,
    S_T3   = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic            ir_e_q,   ir_e_d;
  logic            dinout_q, dinout_d;
  logic [NREG-1:0] rin_q,    rin_d;
  logic [NREG-1:0] rout_q,   rout_d;
  logic            ain_q,    ain_d;
  logic            gin_q,    gin_d;
  logic            gout_q,   gout_d;
  logic [1:0]      aluop_q,  aluop_d;
  logic            done_q,   done_d;

  // Instruction field extraction; only IR[9:0] carries meaning.
  logic [9:0]       ir_f;
  logic [OP_W-1:0]  op;
  logic [REG_W-1:0] rx, ry;
  logic [NREG-1:0]  rx_oh, ry_oh;
  logic             is_alu;
  logic [1:0]       alu_code;

  assign ir_f     = IR[9:0];
  assign op       = ir_f[9:6];
  assign rx       = ir_f[5:3];
  assign ry       = ir_f[2:0];
  assign rx_oh    = NREG'(1) << rx;
  assign ry_oh    = NREG'(1) << ry;
  assign is_alu   = (op >= 4'd2) && (op <= 4'd5);
  // add=0010..or=0101 map onto ALU codes 00..11
  assign alu_code = 2'(op - 4'd2);

  // Next-state sequencing; Run matters only in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (Run) state_d = S_T0;
      S_T0:    state_d = S_T1;
      S_T1:    state_d = is_alu ? S_T2 : S_IDLE;
      S_T2:    state_d = S_T3;
      S_T3:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control word for the state being entered, decoded from IR fields.
  always_comb begin
    ir_e_d   = 1'b0;
    dinout_d = 1'b0;
    rin_d    = '0;
    rout_d   = '0;
    ain_d    = 1'b0;
    gin_d    = 1'b0;
    gout_d   = 1'b0;
    aluop_d  = 2'b00;
    done_d   = 1'b0;
    case (state_d)
      S_T0: begin
        ir_e_d   = 1'b1;
        dinout_d = 1'b1;
      end
      S_T1: begin
        case (op)
          4'b0000: begin
            rout_d = ry_oh;
            rin_d  = rx_oh;
            done_d = 1'b1;
          end
          4'b0001: begin
            dinout_d = 1'b1;
            rin_d    = rx_oh;
            done_d   = 1'b1;
          end
          4'b0010, 4'b0011, 4'b0100, 4'b0101: begin
            rout_d = rx_oh;
            ain_d  = 1'b1;
          end
          default: done_d = 1'b1;
        endcase
      end
      S_T2: begin
        rout_d  = ry_oh;
        gin_d   = 1'b1;
        aluop_d = alu_code;
      end
      S_T3: begin
        gout_d = 1'b1;
        rin_d  = rx_oh;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  // State and control-output registers; reset abandons any instruction at once.
  always_ff @(posedge CLKb or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      ir_e_q   <= 1'b0;
      dinout_q <= 1'b0;
      rin_q    <= '0;
      rout_q   <= '0;
      ain_q    <= 1'b0;
      gin_q    <= 1'b0;
      gout_q   <= 1'b0;
      aluop_q  <= 2'b00;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_e_q   <= ir_e_d;
      dinout_q <= dinout_d;
      rin_q    <= rin_d;
      rout_q   <= rout_d;
      ain_q    <= ain_d;
      gin_q    <= gin_d;
      gout_q   <= gout_d;
      aluop_q  <= aluop_d;
      done_q   <= done_d;
    end
  end

  assign IR_E   = ir_e_q;
  assign DINout = dinout_q;
  assign Rin    = rin_q;
  assign Rout   = rout_q;
  assign Ain    = ain_q;
  assign Gin    = gin_q;
  assign Gout   = gout_q;
  assign ALUop  = aluop_q;
  assign Done   = done_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: stimulus queues the expected control
// word for every active cycle; a monitor pops and compares on each falling edge.
module tb_instr_sequencer;

  logic       CLKb = 1'b0;
  logic       Reset;
  logic       Run;
  logic [9:0] IR;
  logic       IR_E, DINout, Ain, Gin, Gout, Done;
  logic [7:0] Rin, Rout;
  logic [1:0] ALUop;

  int checks = 0;
  int errors = 0;
  int exp_done = 0;
  int act_done = 0;

  logic [23:0] sb[$];

  instr_sequencer #(.N(10), .NREG(8)) dut (
    .CLKb(CLKb), .Reset(Reset), .Run(Run), .IR(IR),
    .IR_E(IR_E), .DINout(DINout), .Rin(Rin), .Rout(Rout),
    .Ain(Ain), .Gin(Gin), .Gout(Gout), .ALUop(ALUop), .Done(Done)
  );

  always #5 CLKb = ~CLKb;

  // {ir_e, dinout, rin, rout, ain, gin, gout, aluop, done}
  function automatic logic [23:0] ev(input bit ir_e, input bit dinout,
                                     input logic [7:0] rin, input logic [7:0] rout,
                                     input bit ain, input bit gin, input bit gout,
                                     input logic [1:0] alu, input bit done);
    return {ir_e, dinout, rin, rout, ain, gin, gout, alu, done};
  endfunction

  function automatic logic [23:0] cur();
    return {IR_E, DINout, Rin, Rout, Ain, Gin, Gout, ALUop, Done};
  endfunction

  task automatic expect_word(input logic [23:0] w);
    sb.push_back(w);
    if (w[0]) exp_done++;
  endtask

  task automatic expect_t0();
    expect_word(ev(1, 1, 8'h00, 8'h00, 0, 0, 0, 2'b00, 0));
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (cur() !== 24'h0) begin
      errors++;
      $display("FAIL %s: outputs=%h required=000000", name, cur());
    end
  endtask

  // Single-cycle Run pulse, then wait for the instruction to drain.
  task automatic run_instr(input logic [9:0] ir, input int wait_cycles);
    @(posedge CLKb); #1;
    IR  = ir;
    Run = 1'b1;
    @(posedge CLKb); #1;
    Run = 1'b0;
    repeat (wait_cycles) @(posedge CLKb);
  endtask

  // Monitor: bus contention every cycle, scoreboard compare on any active cycle.
  always @(negedge CLKb) begin
    logic [23:0] act, exp_w;
    int drivers;
    act     = cur();
    drivers = int'(DINout) + int'(Gout) + $countones(Rout);
    checks++;
    if (drivers > 1) begin
      errors++;
      $display("FAIL bus_contention: drivers=%0d required<=1 word=%h", drivers, act);
    end
    if (Done) act_done++;
    if (act !== 24'h0) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_activity: word=%h required=000000", act);
      end else begin
        exp_w = sb.pop_front();
        if (act !== exp_w) begin
          errors++;
          $display("FAIL control_word: actual=%h required=%h", act, exp_w);
        end
      end
    end
  end

  initial begin
    Reset = 1'b1;
    Run   = 1'b0;
    IR    = 10'h000;
    repeat (2) @(posedge CLKb);
    #1 check_idle("reset_state");
    Reset = 1'b0;
    repeat (2) @(posedge CLKb);
    #1 check_idle("idle_no_run");

    // mv R1,R5 with IR garbage until mid-T0
    expect_t0();
    expect_word(ev(0, 0, 8'h02, 8'h20, 0, 0, 0, 2'b00, 1));
    @(posedge CLKb); #1;
    IR  = 10'b1111_111_111;
    Run = 1'b1;
    @(posedge CLKb); #1;
    Run = 1'b0;
    @(negedge CLKb);
    IR = 10'b0000_001_101;
    repeat (3) @(posedge CLKb);

    // mvi R7
    expect_t0();
    expect_word(ev(0, 1, 8'h80, 8'h00, 0, 0, 0, 2'b00, 1));
    run_instr(10'b0001_111_000, 3);

    // sub R2,R4
    expect_t0();
    expect_word(ev(0, 0, 8'h00, 8'h04, 1, 0, 0, 2'b00, 0));
    expect_word(ev(0, 0, 8'h00, 8'h10, 0, 1, 0, 2'b01, 0));
    expect_word(ev(0, 0, 8'h04, 8'h00, 0, 0, 1, 2'b00, 1));
    run_instr(10'b0011_010_100, 5);

    // add R2,R2
    expect_t0();
    expect_word(ev(0, 0, 8'h00, 8'h04, 1, 0, 0, 2'b00, 0));
    expect_word(ev(0, 0, 8'h00, 8'h04, 0, 1, 0, 2'b00, 0));
    expect_word(ev(0, 0, 8'h04, 8'h00, 0, 0, 1, 2'b00, 1));
    run_instr(10'b0010_010_010, 5);

    // or R0,R7
    expect_t0();
    expect_word(ev(0, 0, 8'h00, 8'h01, 1, 0, 0, 2'b00, 0));
    expect_word(ev(0, 0, 8'h00, 8'h80, 0, 1, 0, 2'b11, 0));
    expect_word(ev(0, 0, 8'h01, 8'h00, 0, 0, 1, 2'b00, 1));
    run_instr(10'b0101_000_111, 5);

    // mv R3,R3
    expect_t0();
    expect_word(ev(0, 0, 8'h08, 8'h08, 0, 0, 0, 2'b00, 1));
    run_instr(10'b0000_011_011, 3);

    // NOP op 1010 with Run held: T0,T1,IDLE,T0,T1
    expect_t0();
    expect_word(ev(0, 0, 8'h00, 8'h00, 0, 0, 0, 2'b00, 1));
    expect_t0();
    expect_word(ev(0, 0, 8'h00, 8'h00, 0, 0, 0, 2'b00, 1));
    @(posedge CLKb); #1;
    IR  = 10'b1010_000_000;
    Run = 1'b1;
    @(posedge CLKb);
    @(posedge CLKb);
    @(posedge CLKb); #1;
    check_idle("idle_between_nops");
    @(posedge CLKb); #1;
    Run = 1'b0;
    repeat (3) @(posedge CLKb);

    // and R5,R6 with Run pulsed in T2
    expect_t0();
    expect_word(ev(0, 0, 8'h00, 8'h20, 1, 0, 0, 2'b00, 0));
    expect_word(ev(0, 0, 8'h00, 8'h40, 0, 1, 0, 2'b10, 0));
    expect_word(ev(0, 0, 8'h20, 8'h00, 0, 0, 1, 2'b00, 1));
    @(posedge CLKb); #1;
    IR  = 10'b0100_101_110;
    Run = 1'b1;
    @(posedge CLKb); #1;
    Run = 1'b0;
    @(posedge CLKb);
    @(posedge CLKb); #1;
    Run = 1'b1;
    @(posedge CLKb); #1;
    Run = 1'b0;
    repeat (4) @(posedge CLKb);
    #1 check_idle("no_extra_fetch");

    // add R1,R3 with reset in T2: only T0 and T1 ever appear
    expect_t0();
    expect_word(ev(0, 0, 8'h00, 8'h02, 1, 0, 0, 2'b00, 0));
    @(posedge CLKb); #1;
    IR  = 10'b0010_001_011;
    Run = 1'b1;
    @(posedge CLKb); #1;
    Run = 1'b0;
    @(posedge CLKb);
    @(posedge CLKb); #2;
    Reset = 1'b1;
    #1 check_idle("async_reset_in_t2");
    Run = 1'b1;
    repeat (2) @(posedge CLKb);
    #1 check_idle("reset_held_with_run");
    Reset = 1'b0;
    Run   = 1'b0;
    repeat (2) @(posedge CLKb);

    // restart after reset: mv R1,R5 from T0
    expect_t0();
    expect_word(ev(0, 0, 8'h02, 8'h20, 0, 0, 0, 2'b00, 1));
    run_instr(10'b0000_001_101, 4);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: pending=%0d required=0", sb.size());
    end
    checks++;
    if (act_done != exp_done) begin
      errors++;
      $display("FAIL done_count: actual=%0d required=%0d", act_done, exp_done);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

endmodule
